// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, MDU hold.
// Ports: ID/EX hazard fields in; PC/IFID/IDEX/EXMEM controls, MDU status, stall stat out.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        IFID_rs,
    input  logic [4:0]        IFID_rt,
    input  logic              IFID_useRt,
    input  logic              IDEX_MemRead,
    input  logic [4:0]        IDEX_dest,
    input  logic              EX_branchTaken,
    input  logic              EX_mduStart,
    input  logic              EX_mduIsDiv,
    input  logic              stat_clr,
    output logic              PC_write,
    output logic              IFID_write,
    output logic              IFID_flush,
    output logic              IDEX_write,
    output logic              IDEX_flush,
    output logic              EXMEM_flush,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [STAT_W-1:0]  r_stall_cnt;

    logic w_busy;
    logic w_acc;
    logic w_last;
    logic w_mstall;
    logic w_lu;

    assign w_busy   = (r_state == S_BUSY);
    assign w_acc    = (r_state == S_IDLE) && EX_mduStart;
    assign w_last   = w_busy && (r_cnt == CNT_ONE);
    // The first (accepting) cycle also stalls, so EX holds for exactly LAT cycles.
    assign w_mstall = w_acc || (w_busy && (r_cnt > CNT_ONE));

    assign w_lu = IDEX_MemRead && (IDEX_dest != 5'd0) &&
                  ((IDEX_dest == IFID_rs) ||
                   (IFID_useRt && (IDEX_dest == IFID_rt)));

    always_comb begin
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IDEX_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        if (reset) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
        end else if (w_mstall) begin
            // Freeze the front end; MEM sees bubbles while EX is occupied.
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            EXMEM_flush = 1'b1;
        end else if (EX_branchTaken) begin
            // Squashes the dependent instruction too, so a coincident
            // load-use needs no bubble.
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
        end else if (w_lu) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_flush  = 1'b1;
        end
    end

    assign mdu_busy  = !reset && w_busy;
    assign mdu_done  = !reset && w_last;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (EX_mduStart) begin
                        r_cnt   <= EX_mduIsDiv ? DIV_INIT : MUL_INIT;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt <= CNT_ONE) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (stat_clr || reset) begin
            r_stall_cnt <= '0;
        end else if (!PC_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It detects load-use hazards that forwarding cannot cover and flushes the wrong-path instructions after a taken branch or jump resolved in EX. It also holds the pipeline while a multi-cycle multiply/divide occupies EX. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers, and keeps a saturating stall-cycle statistic.

Parameters:
MUL_LAT, 4, total EX occupancy (cycles) of mult/multu; must be >= 2
DIV_LAT, 8, total EX occupancy (cycles) of div/divu; must be >= 2
CNT_W, 4, width of the internal latency counter; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)-1
STAT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
IFID_rs  in  5  rs field of the instruction in ID
IFID_rt  in  5  rt field of the instruction in ID
IFID_useRt  in  1  ID instruction reads rt as a source
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_dest  in  5  destination register of the instruction in EX
EX_branchTaken  in  1  taken branch or jump resolved in EX this cycle
EX_mduStart  in  1  instruction in EX is mult/div; held for as long as it stays in EX
EX_mduIsDiv  in  1  qualifies EX_mduStart: 1 = divide, 0 = multiply
stat_clr  in  1  synchronous clear of stall_cnt
PC_write  out  1  PC load enable
IFID_write  out  1  IF/ID load enable
IFID_flush  out  1  clear IF/ID to a NOP
IDEX_write  out  1  ID/EX load enable
IDEX_flush  out  1  load a bubble into ID/EX
EXMEM_flush  out  1  load a bubble into EX/MEM
mdu_busy  out  1  MDU FSM is in BUSY
mdu_done  out  1  single-cycle pulse on the final EX cycle of mult/div; HI/LO write enable
stall_cnt  out  STAT_W  saturating count of cycles with PC_write=0

Behaviour:
- FSM states: IDLE and BUSY. Register cnt is CNT_W bits wide.
- Reset (reset=1): state is IDLE, cnt=0, stall_cnt=0. While reset is high, outputs are PC_write=0, IFID_write=0, IDEX_write=0, IFID_flush=1, IDEX_flush=1, EXMEM_flush=1, mdu_busy=0, mdu_done=0. Reset asserted mid-multiply or mid-divide aborts the operation; mdu_done never pulses for it.
- Accepted start: acc = (state==IDLE) && EX_mduStart. On acc, cnt <= (EX_mduIsDiv ? DIV_LAT : MUL_LAT) - 1 and state <= BUSY.
- BUSY: EX_mduStart is ignored (it is the same held instruction). Each cycle cnt <= cnt-1.
- When cnt==1 in BUSY: mdu_done=1 and state <= IDLE. A new mult/div arriving in EX in the following cycle is accepted normally (back-to-back operation).
- mstall = acc || (state==BUSY && cnt>1). The EX occupancy of a mult/div is exactly LAT cycles: LAT-1 stall cycles plus the done cycle.
- mdu_busy = (state==BUSY).
- lu (load-use) = IDEX_MemRead && IDEX_dest!=0 && (IDEX_dest==IFID_rs || (IFID_useRt && IDEX_dest==IFID_rt)).
- Outputs are combinational from state and inputs. Priority is mstall > EX_branchTaken > lu > default:
  - mstall: PC_write=0, IFID_write=0, IDEX_write=0, EXMEM_flush=1, IFID_flush=0, IDEX_flush=0.
  - branch: PC_write=1, IFID_write=1, IDEX_write=1, IFID_flush=1, IDEX_flush=1, EXMEM_flush=0. A simultaneous lu is discarded, because the dependent instruction is squashed.
  - lu: PC_write=0, IFID_write=0, IDEX_write=1, IDEX_flush=1, IFID_flush=0, EXMEM_flush=0. Exactly one bubble per load-use.
  - default: all write enables 1, all flushes 0.
- stall_cnt: stat_clr has priority and sets it to 0. Otherwise it increments when PC_write==0 and reset==0, and saturates at 2^STAT_W-1 (no wrap).
- A destination of 0 never causes a stall. A flush and a write enable both asserted on a register means "load NOP".

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_dest=8, IFID_rs=8 for 1 cycle -> PC_write=0, IFID_write=0, IDEX_flush=1 that cycle, stall_cnt=1. Repeat with IDEX_dest=0 -> no stall. Repeat with IFID_rt=8, IFID_useRt=0 -> no stall.
- Multiply, MUL_LAT=4: EX_mduStart=1, EX_mduIsDiv=0 held 4 cycles -> PC_write=0 in cycles 0-2, mdu_busy=1 in cycles 1-3, mdu_done=1 only in cycle 3, EXMEM_flush=1 in cycles 0-2, stall_cnt=3.
- Back-to-back divide then multiply (DIV_LAT=8, MUL_LAT=4), start held continuously across the boundary -> two mdu_done pulses 4 cycles apart (cycles 7 and 11) with no IDLE gap; stall_cnt=10.
- Taken branch coincident with load-use (EX_branchTaken=1, lu true) -> IFID_flush=1, IDEX_flush=1, PC_write=1; stall_cnt unchanged.
- Reset in cycle 2 of a divide -> outputs take their reset values in that cycle; no mdu_done afterwards; state is IDLE and a new multiply is accepted on the first cycle after reset deasserts.
- Saturation with STAT_W=4: hold a load-use for 20 cycles -> stall_cnt=15 and stays at 15. Pulse stat_clr together with a stall -> stall_cnt=0.
